// File: rtl/imem_port_arbiter_if.sv
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Fetch, LSU and memory-side signal bundle for imem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_port_arbiter_if #(
    parameter int ADDR_W = 9
);
    // Fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // Load/store port
    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_be;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;

    // Memory port
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Requesters and the memory model together form the environment side
    modport master (
        output if_req, if_addr, if_flush,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-port synchronous memory between fetch and
//               LSU with bounded LSU priority and 1-cycle read-data routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
    parameter int ADDR_W        = 9,
    parameter int MAX_LS_STREAK = 3
) (
    input  wire logic           clk,
    input  wire logic           reset,
    imem_port_arbiter_if.slave  bus
);

    localparam int c_STREAK_W = ($clog2(MAX_LS_STREAK + 1) < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_LS_STREAK);

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_IF   = 2'd1;
    localparam logic [1:0] c_OWN_LS   = 2'd2;

    logic [c_STREAK_W-1:0] r_streak;
    logic [1:0]            r_owner;
    logic [1:0]            w_owner_nxt;

    logic w_if_elig;
    logic w_streak_max;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_ls_rd_gnt;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    assign w_if_elig    = bus.if_req & ~bus.if_flush;
    assign w_streak_max = (r_streak == c_STREAK_MAX);

    // LSU wins contention until the streak limit, then fetch gets one slot
    assign w_ls_gnt    = ~reset & bus.ls_req & ~(w_if_elig & w_streak_max);
    assign w_if_gnt    = ~reset & w_if_elig & ~w_ls_gnt;
    assign w_ls_rd_gnt = w_ls_gnt & ~bus.ls_we;

    assign bus.if_gnt = w_if_gnt;
    assign bus.ls_gnt = w_ls_gnt;

    // ------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------
    assign bus.mem_en    = w_if_gnt | w_ls_gnt;
    assign bus.mem_addr  = w_ls_gnt ? bus.ls_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
    assign bus.mem_we    = (w_ls_gnt & bus.ls_we) ? bus.ls_be : 4'b0000;
    assign bus.mem_wdata = bus.ls_wdata;

    // Byte-offset and upper address bits never reach the word-addressed memory
    logic w_unused;
    assign w_unused = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                        bus.ls_addr[31:ADDR_W+2], bus.ls_addr[1:0]};

    // ------------------------------------------------------------------
    // LSU streak counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_if_gnt || !w_if_elig) begin
            r_streak <= '0;
        end else if (w_ls_gnt && !w_streak_max) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response owner: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= c_OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = c_OWN_NONE;
        if (w_if_gnt) begin
            w_owner_nxt = c_OWN_IF;
        end else if (w_ls_rd_gnt) begin
            w_owner_nxt = c_OWN_LS;
        end
    end

    // A flush in the response cycle drops the stale fetch data only
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;
        if (!reset) begin
            bus.if_rvalid = (r_owner == c_OWN_IF) & ~bus.if_flush;
            bus.ls_rvalid = (r_owner == c_OWN_LS);
        end
    end

    assign bus.if_rdata = bus.mem_rdata;
    assign bus.ls_rdata = bus.mem_rdata;

    a_one_grant : assert property (@(posedge clk) !(w_if_gnt && w_ls_gnt));

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed self-checking bench for imem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(9)) bus ();

    imem_port_arbiter #(
        .ADDR_W        (9),
        .MAX_LS_STREAK (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port synchronous memory, read-before-write, 1-cycle latency
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic flush,
                         input logic lreq, input logic we, input logic [3:0] be,
                         input logic [31:0] laddr, input logic [31:0] wdata);
        bus.if_req   = ireq;
        bus.if_addr  = iaddr;
        bus.if_flush = flush;
        bus.ls_req   = lreq;
        bus.ls_we    = we;
        bus.ls_be    = be;
        bus.ls_addr  = laddr;
        bus.ls_wdata = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Advance one clock; inputs are changed and outputs sampled after the negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic exp_if;
    logic prev_ls;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | i;
        bus.mem_rdata = 32'h0;
        reset = 1'b1;
        idle();

        // Reset with both requesters active
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #1;
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        chk("rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        chk("post_rst_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("post_rst_mem_en", 32'(bus.mem_en), 32'd1);
        step();
        idle();
        #1;
        chk("post_rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("idle_mem_en", 32'(bus.mem_en), 32'd0);

        // Fetch-only read
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("if_only_gnt", 32'(bus.if_gnt), 32'd1);
        chk("if_only_addr", 32'(bus.mem_addr), 32'd4);
        step();
        idle();
        #1;
        chk("if_only_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("if_only_rdata", bus.if_rdata, 32'hA000_0004);
        chk("if_only_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);

        // LSU partial write then read-back
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        #1;
        chk("wr_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("wr_mem_we", 32'(bus.mem_we), 32'b0011);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'd8);
        step();
        idle();
        #1;
        chk("wr_no_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        chk("wr_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #1;
        chk("rd_mem_we", 32'(bus.mem_we), 32'd0);
        step();
        idle();
        #1;
        chk("rd_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("rd_ls_rdata", bus.ls_rdata, 32'hA000_BEEF);

        // Sustained contention: LS LS LS IF LS LS LS IF
        prev_ls = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
            #1;
            exp_if = (k == 3) || (k == 7);
            chk($sformatf("cont_if_gnt_%0d", k), 32'(bus.if_gnt), 32'(exp_if));
            chk($sformatf("cont_ls_gnt_%0d", k), 32'(bus.ls_gnt), 32'(!exp_if));
            chk($sformatf("cont_addr_%0d", k), 32'(bus.mem_addr), exp_if ? 32'd16 : 32'd32);
            if (k > 0) chk($sformatf("cont_ls_rvalid_%0d", k), 32'(bus.ls_rvalid), 32'(prev_ls));
            prev_ls = !exp_if;
            step();
        end
        idle();
        #1;
        chk("cont_last_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("cont_last_if_rdata", bus.if_rdata, 32'hA000_0010);
        step();

        // Flush in a contended cycle resets the streak: LS LS [flush:LS] LS LS LS IF
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'h40, (k == 2), 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
            #1;
            exp_if = (k == 6);
            chk($sformatf("flclr_if_gnt_%0d", k), 32'(bus.if_gnt), 32'(exp_if));
            step();
        end
        idle();
        step();

        // Fetch granted, then flushed during its response cycle
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("fl_if_gnt", 32'(bus.if_gnt), 32'd1);
        step();
        drive(1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
        #1;
        chk("fl_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("fl_if_gnt_blocked", 32'(bus.if_gnt), 32'd0);
        chk("fl_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        step();
        idle();
        #1;
        chk("fl_ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("fl_ls_rdata", bus.ls_rdata, 32'hA000_0020);
        chk("fl_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);

        // LSU read immediately followed by reset
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("rstrd_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rstrd_after_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        chk("rstrd_after_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
